// File: rtl/card_dealer.sv
// Blackjack card source: draws from a 52-card deck without replacement,
// picking each card with a free-running 16-bit LFSR plus a linear probe.
module card_dealer #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_req,
  input  logic       shuffle,
  output logic [3:0] card_value,
  output logic [3:0] card_rank,
  output logic       card_valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       reshuffled
);

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    PROBE
  } state_t;

  localparam logic [5:0] DECK_SIZE = 6'd52;

  state_t      r_state;
  state_t      w_next_state;
  logic [51:0] r_used;
  logic [5:0]  r_idx;
  logic [15:0] r_lfsr;
  logic [3:0]  r_card_value;
  logic [3:0]  r_card_rank;
  logic        r_card_valid;
  logic        r_reshuffled;
  logic [5:0]  r_cards_left;

  logic        w_refill;
  logic        w_take;
  logic [5:0]  w_take_idx;
  logic [5:0]  w_next_idx;
  logic [5:0]  w_cand;
  logic        w_lfsr_fb;
  logic [3:0]  w_rank;

  function automatic logic [5:0] wrap_inc(input logic [5:0] i);
    return (i == 6'd51) ? 6'd0 : i + 6'd1;
  endfunction

  // Rank is the position within the 13-card suit block, 1-based.
  function automatic logic [3:0] rank_of(input logic [5:0] i);
    logic [5:0] t;
    if (i < 6'd13)      t = i;
    else if (i < 6'd26) t = i - 6'd13;
    else if (i < 6'd39) t = i - 6'd26;
    else                t = i - 6'd39;
    return 4'(t) + 4'd1;
  endfunction

  assign w_cand    = r_lfsr[5:0];
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_rank    = rank_of(w_take_idx);

  // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_refill     = 1'b0;
    w_take       = 1'b0;
    w_take_idx   = r_idx;
    w_next_idx   = r_idx;
    case (r_state)
      IDLE: begin
        // An empty deck refills on the same edge that accepts the request.
        if (shuffle || (card_req && (r_cards_left == 6'd0))) w_refill = 1'b1;
        if (card_req) w_next_state = PICK;
      end
      PICK: begin
        if (w_cand < DECK_SIZE) begin
          if (!r_used[w_cand]) begin
            w_take       = 1'b1;
            w_take_idx   = w_cand;
            w_next_state = IDLE;
          end else begin
            w_next_idx   = wrap_inc(w_cand);
            w_next_state = PROBE;
          end
        end
      end
      PROBE: begin
        if (!r_used[r_idx]) begin
          w_take       = 1'b1;
          w_take_idx   = r_idx;
          w_next_state = IDLE;
        end else begin
          w_next_idx = wrap_inc(r_idx);
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the 52-bit used mask is plain flops, so it is reset along with the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_used       <= '0;
      r_idx        <= '0;
      r_lfsr       <= SEED;
      r_card_value <= '0;
      r_card_rank  <= '0;
      r_card_valid <= 1'b0;
      r_reshuffled <= 1'b0;
      r_cards_left <= DECK_SIZE;
    end else begin
      r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
      r_idx        <= w_next_idx;
      r_card_valid <= w_take;
      r_reshuffled <= w_refill;
      if (w_refill) begin
        r_used       <= '0;
        r_cards_left <= DECK_SIZE;
      end else if (w_take) begin
        r_used[w_take_idx] <= 1'b1;
        r_cards_left       <= r_cards_left - 6'd1;
        r_card_rank        <= w_rank;
        r_card_value       <= (w_rank > 4'd10) ? 4'd10 : w_rank;
      end
    end
  end

  assign card_value = r_card_value;
  assign card_rank  = r_card_rank;
  assign card_valid = r_card_valid;
  assign busy       = (r_state != IDLE);
  assign cards_left = r_cards_left;
  assign reshuffled = r_reshuffled;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: stimulus queues expected deliveries,
// a negedge monitor compares each card_valid against the queue.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       card_req;
  logic       shuffle;
  logic [3:0] card_value;
  logic [3:0] card_rank;
  logic       card_valid;
  logic       busy;
  logic [5:0] cards_left;
  logic       reshuffled;

  always #5 clk = ~clk;

  card_dealer #(.SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .card_req   (card_req),
    .shuffle    (shuffle),
    .card_value (card_value),
    .card_rank  (card_rank),
    .card_valid (card_valid),
    .busy       (busy),
    .cards_left (cards_left),
    .reshuffled (reshuffled)
  );

  typedef struct {
    int left;
    bit resh;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   rank_hist[14];
  int   val_hist[11];
  int   cards_got   = 0;
  int   resh_seen   = 0;
  bit   resh_pending = 1'b0;
  int   busy_cnt    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt     = 0;
      resh_pending = 1'b0;
    end else begin
      if (reshuffled) begin
        resh_seen++;
        resh_pending = 1'b1;
      end
      if (busy) busy_cnt++;
      if (card_valid) begin
        cards_got++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cards_left_on_valid", int'(cards_left), e.left);
          check("reshuffle_before_card", int'(resh_pending), int'(e.resh));
        end
        check("rank_range", int'(card_rank >= 4'd1 && card_rank <= 4'd13), 1);
        check("value_vs_rank", int'(card_value), (card_rank > 4'd10) ? 10 : int'(card_rank));
        check("latency_min2", int'(busy_cnt + 1 >= 2), 1);
        check("busy_low_on_valid", int'(busy), 0);
        if (card_rank <= 4'd13) rank_hist[card_rank]++;
        if (card_value <= 4'd10) val_hist[card_value]++;
        busy_cnt     = 0;
        resh_pending = 1'b0;
      end
    end
  end

  task automatic clear_hist();
    for (int i = 0; i < 14; i++) rank_hist[i] = 0;
    for (int i = 0; i < 11; i++) val_hist[i] = 0;
  endtask

  task automatic check_hist();
    for (int r = 1; r <= 13; r++) check($sformatf("rank_count_%0d", r), rank_hist[r], 4);
    for (int v = 1; v <= 9; v++) check($sformatf("value_count_%0d", v), val_hist[v], 4);
    check("value_count_10", val_hist[10], 16);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // One draw; optionally with shuffle in the same cycle, optionally
  // pulsing card_req up to ignore_pulses times while busy.
  task automatic do_req(input int exp_left, input bit exp_resh,
                        input bit with_shuffle, input int ignore_pulses);
    exp_t e;
    bit   got;
    int   pulses;
    e.left = exp_left;
    e.resh = exp_resh;
    exp_q.push_back(e);
    got    = 1'b0;
    pulses = 0;
    card_req = 1'b1;
    shuffle  = with_shuffle;
    @(posedge clk);
    #1;
    card_req = 1'b0;
    shuffle  = 1'b0;
    check("busy_after_req", int'(busy), 1);
    if (with_shuffle) check("reshuffled_on_shuffle_req", int'(reshuffled), 1);
    for (int n = 0; n < 400 && !got; n++) begin
      if (pulses < ignore_pulses && busy) begin
        card_req = 1'b1;
        pulses++;
      end
      @(posedge clk);
      #1;
      card_req = 1'b0;
      if (card_valid) got = 1'b1;
    end
    if (!got) check("draw_timeout", 0, 1);
  endtask

  initial begin
    int r0;
    rst      = 1'b1;
    card_req = 1'b0;
    shuffle  = 1'b0;
    clear_hist();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cards_left", int'(cards_left), 52);
    check("rst_busy", int'(busy), 0);
    check("rst_card_valid", int'(card_valid), 0);
    check("rst_reshuffled", int'(reshuffled), 0);
    check("rst_card_value", int'(card_value), 0);
    check("rst_card_rank", int'(card_rank), 0);
    rst = 1'b0;

    // Abort a draw in flight with reset.
    repeat (3) @(posedge clk);
    #1;
    card_req = 1'b1;
    @(posedge clk);
    #1;
    card_req = 1'b0;
    check("busy_before_abort", int'(busy), 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_cards_left", int'(cards_left), 52);
    check("abort_busy", int'(busy), 0);
    check("abort_card_valid", int'(card_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Full deck, back-to-back.
    clear_hist();
    for (int i = 0; i < 52; i++) do_req(51 - i, 1'b0, 1'b0, 0);
    settle();
    check_hist();
    check("deck_empty", int'(cards_left), 0);

    // Auto-refill on the 53rd request.
    r0 = resh_seen;
    do_req(51, 1'b1, 1'b0, 0);
    settle();
    check("auto_refill_pulses", resh_seen - r0, 1);

    // Ten cards drawn since refill, then an explicit shuffle.
    for (int i = 0; i < 9; i++) do_req(50 - i, 1'b0, 1'b0, 0);
    shuffle = 1'b1;
    @(posedge clk);
    #1;
    shuffle = 1'b0;
    check("shuffle_reshuffled", int'(reshuffled), 1);
    check("shuffle_cards_left", int'(cards_left), 52);
    check("shuffle_busy", int'(busy), 0);
    clear_hist();
    for (int i = 0; i < 52; i++) do_req(51 - i, (i == 0), 1'b0, 0);
    settle();
    check_hist();

    // Requests while busy are dropped (deck is empty, so this also refills).
    do_req(51, 1'b1, 1'b0, 5);
    repeat (10) @(posedge clk);
    #1;
    check("ignore_cards_left", int'(cards_left), 51);
    check("ignore_busy", int'(busy), 0);

    // Shuffle and request together after 20 draws.
    for (int i = 0; i < 19; i++) do_req(50 - i, 1'b0, 1'b0, 0);
    do_req(51, 1'b1, 1'b1, 0);

    repeat (5) @(posedge clk);
    settle();
    check("queue_drained", exp_q.size(), 0);
    check("total_cards", cards_got, 135);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Card source for the blackjack datapath. It holds a single 52-card deck as a used-card bitmap and draws cards without replacement, using a free-running LFSR to pick each card. It returns the blackjack value on a request/valid handshake, ready for `blackjack_fsm`'s `card_value` input. It sits between the pushbutton/controller logic, which issues `card_req`, and the game FSM and display, which consume `card_value` and `card_rank`.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.
- `clk`  in  1: single system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `card_req`  in  1: draw request. Sampled only in IDLE.
- `shuffle`  in  1: return all 52 cards to the deck. Sampled only in IDLE.
- `card_value`  out  4: blackjack value 1..10. Ace is 1; J, Q and K are 10. Held until the next delivery.
- `card_rank`  out  4: rank 1..13 (A=1 … K=13). Held, same timing as `card_value`.
- `card_valid`  out  1: one-cycle pulse when a new card is presented.
- `busy`  out  1: high while a draw is in progress.
- `cards_left`  out  6: undrawn cards, range 0..52.
- `reshuffled`  out  1: one-cycle pulse when the deck refills, whether by `shuffle` or by auto-refill.

## Operation
- Deck index `i` runs 0..51. Rank = (`i` mod 13) + 1. Value = min(rank, 10).
- Internal state:
  - 52-bit `used` mask.
  - 6-bit candidate index `idx`.
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
- The LFSR shifts every cycle in every state. Idle time therefore randomises the next draw.
- FSM states are IDLE, PICK and PROBE.
- IDLE:
  - If `shuffle`=1: clear `used`, set `cards_left`=52, pulse `reshuffled`.
  - If `card_req`=1: go to PICK and assert `busy`.
  - If `card_req`=1 and `cards_left`=0: auto-refill in the same edge (clear `used`, set `cards_left`=52, pulse `reshuffled`), then go to PICK.
  - If `shuffle` and `card_req` are both 1: the shuffle takes effect first, and the draw is made from the full deck.
- PICK:
  - Candidate c = `lfsr[5:0]`.
  - If c ≥ 52: stay in PICK (rejection sampling).
  - If c < 52 and `used[c]`=0: take the card (see below).
  - If c < 52 and `used[c]`=1: set `idx` = c+1 (wrapping 51→0) and go to PROBE.
- PROBE: test `idx` each cycle.
  - If free: take it.
  - If used: `idx` = `idx`+1, wrapping 51→0.
  - Reaching PROBE implies at least one free card, so PROBE lasts at most 51 cycles.
- Take card, all on one edge:
  - Set `used[i]`.
  - `cards_left` -= 1.
  - Register `card_value` and `card_rank`.
  - `card_valid` <= 1 for exactly one cycle.
  - `busy` <= 0.
  - Return to IDLE.
- `card_req` and `shuffle` are ignored while `busy`=1. They are not queued.
- `cards_left` never underflows. Decrement happens only on a take, and a take implies a free card exists.

## Timing
- Reset values: IDLE, `used`=0, `lfsr`=SEED, `card_value`=0, `card_rank`=0, `card_valid`=0, `busy`=0, `cards_left`=52, `reshuffled`=0.
- Reset asserted mid-draw aborts the draw. No `card_valid` pulse follows, and all reset values apply immediately.
- Latency from the `card_req` edge to `card_valid` high:
  - Minimum 2 cycles: request edge, then a PICK hit edge.
  - Extra cycles are 1 per LFSR rejection plus 1 per PROBE step.
- `card_valid`, `busy`=0, the decremented `cards_left`, and the new `card_value`/`card_rank` all become visible on the same edge.
- A new `card_req` is accepted in the cycle `card_valid` is high, because the FSM is already in IDLE.
- `reshuffled` is high on the cycle after the IDLE edge that refilled the deck.
- `card_valid` and `reshuffled` are never asserted on consecutive cycles by the same event.

## Test plan
- Reset, then hold `rst`=1 mid-draw:
  - Outputs must equal the reset values: `cards_left`=52, `busy`=0, `card_valid`=0.
  - No `card_valid` pulse may appear after `rst` is released.
- Issue 52 requests, each sent as soon as the previous `card_valid` arrives:
  - Exactly 52 `card_valid` pulses.
  - Each of ranks 1..13 appears 4 times.
  - Value histogram: 10 appears 16 times; each of 1..9 appears 4 times.
  - `cards_left` steps 52→0.
  - Every draw latency is ≥2 cycles.
- 53rd request with `cards_left`=0:
  - `reshuffled` pulses once.
  - The card is delivered, and `cards_left`=51.
- Draw 10 cards, pulse `shuffle` in IDLE:
  - `reshuffled` pulses and `cards_left`=52.
  - The next 52 draws again give 4 of each rank.
- Pulse `card_req` 5 times while `busy`=1: only the one in-flight card is delivered, and `cards_left` decrements by exactly 1.
- `shuffle` and `card_req` in the same IDLE cycle after 20 draws:
  - `reshuffled` pulses.
  - After `card_valid`, `cards_left`=51.
